// File: rtl/uart_out_mux.sv
// Merges N_SRC byte producers into one shared FIFO drained by an 8N1 UART transmitter.
// Define UART_OUT_PARITY_EN to insert an even-parity bit (8E1 framing, 11 bit periods).
module uart_out_mux #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int N_SRC            = 2,
  parameter int DEPTH            = 4096,
  parameter int ARB_RR           = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         wr_en,
  input  logic [8*N_SRC-1:0]       wr_data,
  input  logic                     flush,
  output logic [N_SRC-1:0]         stall,
  output logic                     txd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     io_end
);
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int GW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_OUT_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant;
  logic          grant_valid;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;
  logic [7:0]    wr_byte;
  int            idx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [2:0]    state;
  logic [TW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;
`ifdef UART_OUT_PARITY_EN
  logic          parity;
`endif

  // Fixed priority scans from index 0; round-robin scans from last_grant+1.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 0; k < N_SRC; k++) begin
      if (ARB_RR != 0) idx = (int'(last_grant) + 1 + k) % N_SRC;
      else             idx = k;
      for (int j = 0; j < N_SRC; j++) begin
        if (j == idx && wr_en[j] && !grant_valid) begin
          grant_valid = 1'b1;
          grant       = GW'(j);
        end
      end
    end
  end

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign accept = grant_valid & ~full & ~flush;

  // Handshake: a source holds wr_en/wr_data until a cycle where its stall bit is
  // low; the byte is taken at that cycle's clock edge.
  always_comb begin
    stall   = wr_en;
    wr_byte = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (GW'(j) == grant) begin
        wr_byte = wr_data[8*j +: 8];
        if (accept) stall[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      last_grant <= GW'(N_SRC - 1);
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bit_done = (bit_cnt == TW'(BIT_CYC - 1));
  // Popping straight out of STOP keeps consecutive frames gap-free.
  assign pop = ~empty & ~flush & ((state == S_IDLE) | ((state == S_STOP) & bit_done));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_OUT_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
      if (pop) begin
        shreg  <= mem[rd_ptr];
`ifdef UART_OUT_PARITY_EN
        parity <= ^mem[rd_ptr];
`endif
      end
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (pop) state <= S_START;
        end
        S_START: if (bit_done) state <= S_DATA;
        S_DATA: if (bit_done) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_OUT_PARITY_EN
          if (bit_idx == 3'd7) state <= S_PARITY;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_OUT_PARITY_EN
        S_PARITY: if (bit_done) state <= S_STOP;
`endif
        S_STOP: if (bit_done) state <= pop ? S_START : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shreg[0];
`ifdef UART_OUT_PARITY_EN
      S_PARITY: txd = parity;
`endif
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) io_end <= 1'b1;
    else       io_end <= empty & (state == S_IDLE);
  end
endmodule
